// File: rtl/lf_spi_status_tx_pkg.sv
// Shared types for the FPGA->ARM status SPI transmitter.
//   lf_tx_state_e : transmitter FSM state codes
//   SeqW          : width of the optional frame sequence tag (LF_SPI_TX_SEQ_EN builds)
//   cnt_width()   : bit counter width able to hold the value WORD_W
package lf_spi_status_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } lf_tx_state_e;

  localparam int unsigned SeqW = 4;

  function automatic int unsigned cnt_width(input int unsigned word_w);
    return $clog2(word_w) + 1;
  endfunction

endpackage

// File: rtl/lf_spi_status_tx_if.sv
// Bus bundle between the ARM-facing SPI pins / status source and lf_spi_status_tx.
//   spck, ncs : SPI clock and chip select from the ARM (asynchronous to pck0)
//   miso      : serial status data to the ARM
//   tx_word   : status word offered for the next frame
//   tx_taken  : pulse, tx_word captured
//   tx_done   : pulse, full word clocked out
//   busy      : frame in progress
// Modports: master = ARM/status-source side, slave = the transmitter.
interface lf_spi_status_tx_if #(
  parameter int unsigned WORD_W = 16
) ();

  logic              spck;
  logic              ncs;
  logic              miso;
  logic [WORD_W-1:0] tx_word;
  logic              tx_taken;
  logic              tx_done;
  logic              busy;

  modport master (
    output spck, ncs, tx_word,
    input  miso, tx_taken, tx_done, busy
  );

  modport slave (
    input  spck, ncs, tx_word,
    output miso, tx_taken, tx_done, busy
  );

endinterface

// File: rtl/lf_sync_edge.sv
// Synchronizer plus edge detector for a slow asynchronous level (spck/ncs).
//   clk_i  : sampling clock
//   rst_i  : synchronous active-high reset; chain reset to IdleVal
//   sig_i  : asynchronous input level
//   rise_o : one-cycle pulse on a synchronized 0->1 transition
//   fall_o : one-cycle pulse on a synchronized 1->0 transition
module lf_sync_edge #(
  parameter int unsigned SyncStages = 2,
  parameter bit          IdleVal    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  // sync_q[0] is the first (metastable-facing) stage
  logic [SyncStages-1:0] sync_q;
  logic                  rise_q;
  logic                  fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SyncStages{IdleVal}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], sig_i};
      rise_q <= sync_q[SyncStages-2] & ~sync_q[SyncStages-1];
      fall_q <= ~sync_q[SyncStages-2] & sync_q[SyncStages-1];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/lf_spi_status_tx.sv
// FPGA->ARM status transmitter on the ARM configuration SPI link (SPI mode 0, MSB first).
// spck/ncs are oversampled in the pck0 domain; no other clock is used.
//   pck0 : system clock
//   rst  : synchronous active-high reset
//   bus  : lf_spi_status_tx_if.slave (spck, ncs, tx_word in; miso, tx_taken, tx_done, busy out)
// Optional feature macro LF_SPI_TX_SEQ_EN: replaces the top 4 bits of each captured word with a
// frame sequence count that advances on every completed frame.
module lf_spi_status_tx
  import lf_spi_status_tx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WORD_W      = 16
) (
  input logic                 pck0,
  input logic                 rst,
  lf_spi_status_tx_if.slave   bus
);

  localparam int unsigned          CntW   = cnt_width(WORD_W);
  localparam logic [CntW-1:0]      CntMax = CntW'(WORD_W);

  logic spck_rise, spck_fall, ncs_rise, ncs_fall;

  lf_sync_edge #(
    .SyncStages (SYNC_STAGES),
    .IdleVal    (1'b0)
  ) u_sync_spck (
    .clk_i  (pck0),
    .rst_i  (rst),
    .sig_i  (bus.spck),
    .rise_o (spck_rise),
    .fall_o (spck_fall)
  );

  lf_sync_edge #(
    .SyncStages (SYNC_STAGES),
    .IdleVal    (1'b1)
  ) u_sync_ncs (
    .clk_i  (pck0),
    .rst_i  (rst),
    .sig_i  (bus.ncs),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  lf_tx_state_e      state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              miso_q, miso_d;
  logic              tx_taken_q, tx_taken_d;
  logic              tx_done_q, tx_done_d;
  logic [WORD_W-1:0] cap_word;

`ifdef LF_SPI_TX_SEQ_EN
  logic [SeqW-1:0] seq_q, seq_d;

  assign cap_word = {seq_q, bus.tx_word[WORD_W-SeqW-1:0]};
  assign seq_d    = tx_done_d ? seq_q + 1'b1 : seq_q;

  always_ff @(posedge pck0) begin
    if (rst) seq_q <= '0;
    else     seq_q <= seq_d;
  end
`else
  assign cap_word = bus.tx_word;
`endif

  always_ff @(posedge pck0) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      tx_taken_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      tx_taken_q <= tx_taken_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;
    tx_taken_d = 1'b0;
    tx_done_d  = 1'b0;
    // End of frame overrides everything, including a coincident spck edge
    if (ncs_rise) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ncs_fall) begin
            state_d    = StShift;
            shreg_d    = cap_word;
            miso_d     = cap_word[WORD_W-1];
            bit_cnt_d  = '0;
            tx_taken_d = 1'b1;
          end
        end
        StShift: begin
          // ARM samples on rise, so the next bit is presented on the following fall
          if (spck_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_d == CntMax) begin
              state_d   = StDone;
              miso_d    = 1'b0;
              tx_done_d = 1'b1;
            end
          end else if (spck_fall && (bit_cnt_q < CntMax)) begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            miso_d  = shreg_q[WORD_W-2];
          end
        end
        StDone: begin
          // Extra clocks from the ARM are ignored until ncs rises
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.miso     = miso_q;
  assign bus.tx_taken = tx_taken_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_lf_spi_status_tx.sv
// Bench for lf_spi_status_tx: acts as the ARM master (8-cycle spck phases), queues the expected
// miso bits when a frame starts and pops them at each spck rise, where the ARM samples.
module tb_lf_spi_status_tx;

  localparam int unsigned WordW = 16;
  localparam int unsigned Half  = 8;
`ifdef LF_SPI_TX_SEQ_EN
  localparam bit SeqEn = 1'b1;
`else
  localparam bit SeqEn = 1'b0;
`endif

  logic pck0 = 1'b0;
  logic rst;

  always #5 pck0 = ~pck0;

  lf_spi_status_tx_if #(.WORD_W(WordW)) bus ();

  lf_spi_status_tx #(
    .SYNC_STAGES (2),
    .WORD_W      (WordW)
  ) dut (
    .pck0 (pck0),
    .rst  (rst),
    .bus  (bus)
  );

  int       n_checks  = 0;
  int       n_fails   = 0;
  int       taken_cnt = 0;
  int       done_cnt  = 0;
  bit       toggle_en = 1'b0;
  logic [3:0] seq_m   = 4'd0;
  logic     exp_q[$];

  always @(negedge pck0) begin
    if (bus.tx_taken === 1'b1) taken_cnt++;
    if (bus.tx_done === 1'b1)  done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge pck0);
      if (toggle_en) bus.tx_word = 16'($urandom);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] w);
    return SeqEn ? {seq_m, w[11:0]} : w;
  endfunction

  task automatic start_frame(input logic [15:0] w);
    logic [15:0] ew;
    bus.tx_word = w;
    ew = exp_word(w);
    exp_q.delete();
    for (int i = 15; i >= 0; i--) exp_q.push_back(ew[i]);
    bus.ncs = 1'b0;
    tick(Half);
  endtask

  task automatic pulse(input string tag);
    logic e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = 1'b0;
    check_eq(tag, 32'(bus.miso), 32'(e));
    bus.spck = 1'b1;
    tick(Half);
    bus.spck = 1'b0;
    tick(Half);
  endtask

  task automatic end_frame(input bit complete);
    bus.ncs = 1'b1;
    tick(Half);
    if (complete) seq_m++;
    exp_q.delete();
  endtask

  initial begin
    int d0;
    int t0;
    rst         = 1'b1;
    bus.spck    = 1'b0;
    bus.ncs     = 1'b1;
    bus.tx_word = '0;
    tick(3);
    rst = 1'b0;
    check_eq("reset_miso", 32'(bus.miso), 32'd0);
    check_eq("reset_busy", 32'(bus.busy), 32'd0);
    check_eq("reset_taken", 32'(bus.tx_taken), 32'd0);
    check_eq("reset_done", 32'(bus.tx_done), 32'd0);
    tick(4);

    // Full frame A5C3
    t0 = taken_cnt;
    d0 = done_cnt;
    start_frame(16'hA5C3);
    check_eq("a5c3_busy_start", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 16; i++) pulse("a5c3_bit");
    check_eq("a5c3_taken_cnt", 32'(taken_cnt - t0), 32'd1);
    check_eq("a5c3_done_cnt", 32'(done_cnt - d0), 32'd1);
    check_eq("a5c3_busy_done", 32'(bus.busy), 32'd1);
    check_eq("a5c3_miso_done", 32'(bus.miso), 32'd0);
    end_frame(1'b1);
    check_eq("a5c3_busy_end", 32'(bus.busy), 32'd0);

    // Abort after 5 bits
    d0 = done_cnt;
    start_frame(16'h1234);
    for (int i = 0; i < 5; i++) pulse("abort_bit");
    end_frame(1'b0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_miso", 32'(bus.miso), 32'd0);
    check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Next frame after abort
    d0 = done_cnt;
    start_frame(16'h0F0F);
    for (int i = 0; i < 16; i++) pulse("0f0f_bit");
    check_eq("0f0f_done_cnt", 32'(done_cnt - d0), 32'd1);
    end_frame(1'b1);

    // Overlong frame: extra bits read as 0, single tx_done
    d0 = done_cnt;
    start_frame(16'h3C96);
    for (int i = 0; i < 20; i++) pulse("long_bit");
    check_eq("long_done_cnt", 32'(done_cnt - d0), 32'd1);
    end_frame(1'b1);

    // tx_word churning after capture
    start_frame(16'h6E1D);
    toggle_en = 1'b1;
    for (int i = 0; i < 16; i++) pulse("toggle_bit");
    toggle_en = 1'b0;
    end_frame(1'b1);

    // Reset in the middle of a frame
    start_frame(16'hB00B);
    for (int i = 0; i < 8; i++) pulse("prerst_bit");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("midrst_miso", 32'(bus.miso), 32'd0);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    bus.ncs = 1'b1;
    tick(2 * Half);
    exp_q.delete();
    d0 = done_cnt;
    start_frame(16'h7A51);
    for (int i = 0; i < 16; i++) pulse("postrst_bit");
    check_eq("postrst_done_cnt", 32'(done_cnt - d0), 32'd1);
    end_frame(1'b1);
    check_eq("postrst_busy_end", 32'(bus.busy), 32'd0);

`ifdef LF_SPI_TX_SEQ_EN
    // Sequence tag over 17 frames, then an aborted frame must not advance it
    for (int f = 0; f < 17; f++) begin
      start_frame(16'h0123);
      for (int i = 0; i < 16; i++) pulse("seq_bit");
      end_frame(1'b1);
    end
    start_frame(16'h0123);
    for (int i = 0; i < 3; i++) pulse("seq_abort_bit");
    end_frame(1'b0);
    start_frame(16'h0123);
    for (int i = 0; i < 16; i++) pulse("seq_after_abort_bit");
    end_frame(1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
